wb_arbiter: RTL and testbench

//  Writeback transmitter and CDB arbiter feeding the ROB's single writeback port (wb_valid/wb_ready/wb_pkt).

---
 rtl/wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU one-entry holding buffers feeding the ROB's single
// writeback port, with mispredict-first round-robin selection and a grant hold
// that keeps the presented packet frozen while the ROB back-pressures.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   fu_valid      per-FU packet offered
//   fu_ready      per-FU packet accepted this cycle
//   fu_pkt        per-FU writeback packet
//   flush_valid   pipeline nuke; discards every buffered packet
//   wb_valid      packet presented to the ROB
//   wb_ready      ROB accepts
//   wb_pkt        selected packet (always taken from a holding buffer)
//   wb_grant_idx  source FU of wb_pkt
//   cdb_fire      wb_valid && wb_ready; wakeup broadcast strobe

package wb_arbiter_pkg;

    localparam int unsigned ROB_IDX_W = 6;
    localparam int unsigned EPOCH_W   = 2;
    localparam int unsigned DATA_W    = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [EPOCH_W-1:0]   epoch;
        logic                 is_branch;
        logic                 mispredict;
        logic                 exc;
        logic [DATA_W-1:0]    data;
    } fu_wb_t;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_FU = 4,
    localparam int unsigned FU_W   = $clog2(NUM_FU)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_FU-1:0]       fu_valid,
    output logic [NUM_FU-1:0]       fu_ready,
    input  fu_wb_t [NUM_FU-1:0]     fu_pkt,
    input  logic                    flush_valid,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output fu_wb_t                  wb_pkt,
    output logic [FU_W-1:0]         wb_grant_idx,
    output logic                    cdb_fire
);

    logic [NUM_FU-1:0] buf_valid_q, buf_valid_d;
    fu_wb_t            buf_pkt_q [NUM_FU];
    fu_wb_t            buf_pkt_d [NUM_FU];
    logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              hold_q, hold_d;
    logic [FU_W-1:0]   hold_idx_q, hold_idx_d;

    logic [NUM_FU-1:0] mp_req;
    logic [NUM_FU-1:0] req;
    logic [FU_W-1:0]   cand;
    logic [FU_W-1:0]   rr_idx;
    logic              rr_found;
    logic [FU_W-1:0]   grant;
    logic              any_valid;

    // Winner selection: mispredicts form a higher class; round-robin within class.
    // A held grant overrides selection so a stalled beat is never displaced.
    always_comb begin
        mp_req   = '0;
        cand     = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            mp_req[i] = buf_valid_q[i] && buf_pkt_q[i].is_branch && buf_pkt_q[i].mispredict;
        end
        req = (|mp_req) ? mp_req : buf_valid_q;
        for (int k = 0; k < int'(NUM_FU); k++) begin
            cand = FU_W'((int'(rr_ptr_q) + k) % int'(NUM_FU));
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        grant = hold_q ? hold_idx_q : rr_idx;
    end

    assign any_valid    = |buf_valid_q;
    assign wb_valid     = any_valid && !flush_valid;
    assign cdb_fire     = wb_valid && wb_ready;
    assign wb_pkt       = any_valid ? buf_pkt_q[grant] : '0;
    assign wb_grant_idx = any_valid ? grant : '0;

    // A port is ready when its buffer is empty or is draining this very cycle.
    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            fu_ready[i] = !flush_valid &&
                          (!buf_valid_q[i] || (cdb_fire && (grant == FU_W'(i))));
        end
    end

    // Next-state: buffer fill/drain, round-robin pointer, grant hold.
    always_comb begin
        buf_valid_d = buf_valid_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        hold_idx_d  = hold_idx_q;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            buf_pkt_d[i] = buf_pkt_q[i];
        end

        if (flush_valid) begin
            buf_valid_d = '0;
            rr_ptr_d    = '0;
            hold_d      = 1'b0;
            hold_idx_d  = '0;
        end else begin
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    buf_valid_d[i] = 1'b1;
                    buf_pkt_d[i]   = fu_pkt[i];
                end else if (cdb_fire && (grant == FU_W'(i))) begin
                    buf_valid_d[i] = 1'b0;
                end
            end
            if (cdb_fire) begin
                hold_d   = 1'b0;
                rr_ptr_d = (grant == FU_W'(NUM_FU - 1)) ? '0 : grant + FU_W'(1);
            end else if (wb_valid) begin
                hold_d     = 1'b1;
                hold_idx_d = grant;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                buf_pkt_q[i] <= '0;
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                buf_pkt_q[i] <= buf_pkt_d[i];
            end
        end
    end

`ifdef SIM
    // A stalled beat stays put unless a flush discards it.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && !wb_ready) |=>
            (flush_valid || (wb_valid && $stable(wb_pkt) && $stable(wb_grant_idx))));

    a_grant_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(wb_grant_idx) < NUM_FU);

    // Delivering from an empty buffer would duplicate a packet.
    a_fire_from_full: assert property (@(posedge clk) disable iff (!rst_n)
        cdb_fire |-> buf_valid_q[grant]);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single beat, round-robin, mispredict priority,
// back-pressure hold, flush and asynchronous reset mid-stall.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      fu_valid;
    logic [3:0]      fu_ready;
    fu_wb_t [3:0]    fu_pkt;
    logic            flush_valid;
    logic            wb_valid;
    logic            wb_ready;
    fu_wb_t          wb_pkt;
    logic [1:0]      wb_grant_idx;
    logic            cdb_fire;

    int errors = 0;
    int checks = 0;

    wb_arbiter #(.NUM_FU(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_pkt       (fu_pkt),
        .flush_valid  (flush_valid),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_pkt       (wb_pkt),
        .wb_grant_idx (wb_grant_idx),
        .cdb_fire     (cdb_fire)
    );

    always #5 clk = ~clk;

    function automatic fu_wb_t mk(input logic [5:0] rob, input logic br, input logic mp);
        fu_wb_t p;
        p            = '0;
        p.rob_idx    = rob;
        p.epoch      = 2'd1;
        p.is_branch  = br;
        p.mispredict = mp;
        p.data       = 32'hA000_0000 | 32'(rob);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive just after the active edge; sample on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_valid = 1'b0;
        fu_valid    = '0;
        wb_ready    = 1'b1;
        fu_pkt      = '0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_cdb_fire", 64'(cdb_fire), 64'd0);
        chk("rst_wb_pkt",   64'(wb_pkt),   64'd0);
        chk("rst_grant",    64'(wb_grant_idx), 64'd0);
        chk("rst_fu_ready", 64'(fu_ready), 64'hF);
        nxt();
        rst_n = 1'b1;

        // T1: single packet from FU2
        fu_valid  = 4'b0100;
        fu_pkt[2] = mk(6'd5, 1'b0, 1'b0);
        smp();
        chk("t1_ready_c0", 64'(fu_ready), 64'hF);
        chk("t1_valid_c0", 64'(wb_valid), 64'd0);
        nxt();
        fu_valid = '0;
        smp();
        chk("t1_valid_c1", 64'(wb_valid), 64'd1);
        chk("t1_rob_c1",   64'(wb_pkt.rob_idx), 64'd5);
        chk("t1_pkt_c1",   64'(wb_pkt), 64'(mk(6'd5, 1'b0, 1'b0)));
        chk("t1_grant_c1", 64'(wb_grant_idx), 64'd2);
        chk("t1_fire_c1",  64'(cdb_fire), 64'd1);
        nxt();
        smp();
        chk("t1_valid_c2", 64'(wb_valid), 64'd0);
        chk("t1_ready_c2", 64'(fu_ready), 64'hF);

        // T2: round-robin with all FUs offering, rr_ptr cleared by a flush
        nxt();
        flush_valid = 1'b1;
        smp();
        nxt();
        flush_valid = 1'b0;
        fu_valid    = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(6'(16 + i), 1'b0, 1'b0);
        smp();
        chk("t2_valid_c0", 64'(wb_valid), 64'd0);
        for (int c = 0; c < 5; c++) begin
            nxt();
            if (c == 4) fu_valid = '0;
            smp();
            chk("t2_grant", 64'(wb_grant_idx), 64'(c % 4));
            chk("t2_rob",   64'(wb_pkt.rob_idx), 64'(16 + (c % 4)));
            chk("t2_ready", 64'(fu_ready), 64'(4'b0001 << (c % 4)));
            chk("t2_fire",  64'(cdb_fire), 64'd1);
        end
        for (int c = 1; c < 4; c++) begin
            nxt();
            smp();
            chk("t2_drain_grant", 64'(wb_grant_idx), 64'(c));
        end
        nxt();
        smp();
        chk("t2_empty", 64'(wb_valid), 64'd0);

        // T3: mispredict on FU1 beats ALU on FU0 with rr_ptr=0
        nxt();
        fu_valid  = 4'b0011;
        fu_pkt[0] = mk(6'd1, 1'b0, 1'b0);
        fu_pkt[1] = mk(6'd9, 1'b1, 1'b1);
        smp();
        nxt();
        fu_valid = '0;
        smp();
        chk("t3_grant_mp", 64'(wb_grant_idx), 64'd1);
        chk("t3_rob_mp",   64'(wb_pkt.rob_idx), 64'd9);
        nxt();
        smp();
        chk("t3_grant_alu", 64'(wb_grant_idx), 64'd0);
        chk("t3_rob_alu",   64'(wb_pkt.rob_idx), 64'd1);
        nxt();
        smp();
        chk("t3_empty", 64'(wb_valid), 64'd0);

        // T4: back-pressure holds FU3 against a later mispredict on FU1
        nxt();
        wb_ready  = 1'b0;
        fu_valid  = 4'b1000;
        fu_pkt[3] = mk(6'd3, 1'b0, 1'b0);
        smp();
        nxt();
        fu_valid  = 4'b0010;
        fu_pkt[1] = mk(6'd11, 1'b1, 1'b1);
        smp();
        chk("t4_grant_s1", 64'(wb_grant_idx), 64'd3);
        chk("t4_fire_s1",  64'(cdb_fire), 64'd0);
        chk("t4_ready_s1", 64'(fu_ready), 64'b0111);
        nxt();
        fu_valid = '0;
        smp();
        chk("t4_ready_s2", 64'(fu_ready), 64'b0101);
        for (int c = 0; c < 4; c++) begin
            if (c != 0) begin
                nxt();
                smp();
            end
            chk("t4_hold_grant", 64'(wb_grant_idx), 64'd3);
            chk("t4_hold_rob",   64'(wb_pkt.rob_idx), 64'd3);
        end
        nxt();
        wb_ready = 1'b1;
        smp();
        chk("t4_rel_grant", 64'(wb_grant_idx), 64'd3);
        chk("t4_rel_fire",  64'(cdb_fire), 64'd1);
        chk("t4_rel_ready", 64'(fu_ready), 64'b1101);
        nxt();
        smp();
        chk("t4_mp_grant", 64'(wb_grant_idx), 64'd1);
        chk("t4_mp_rob",   64'(wb_pkt.rob_idx), 64'd11);
        nxt();
        smp();
        chk("t4_empty", 64'(wb_valid), 64'd0);

        // T5: flush with three buffers full
        nxt();
        wb_ready = 1'b0;
        fu_valid = 4'b0111;
        for (int i = 0; i < 3; i++) fu_pkt[i] = mk(6'(20 + i), 1'b0, 1'b0);
        smp();
        nxt();
        fu_valid    = 4'b1000;
        fu_pkt[3]   = mk(6'd23, 1'b0, 1'b0);
        flush_valid = 1'b1;
        smp();
        chk("t5_fl_valid", 64'(wb_valid), 64'd0);
        chk("t5_fl_ready", 64'(fu_ready), 64'd0);
        chk("t5_fl_fire",  64'(cdb_fire), 64'd0);
        nxt();
        flush_valid = 1'b0;
        fu_valid    = '0;
        wb_ready    = 1'b1;
        smp();
        chk("t5_post_valid", 64'(wb_valid), 64'd0);
        chk("t5_post_ready", 64'(fu_ready), 64'hF);
        nxt();
        smp();
        chk("t5_post_fire", 64'(cdb_fire), 64'd0);
        nxt();
        fu_valid  = 4'b1010;
        fu_pkt[1] = mk(6'd31, 1'b0, 1'b0);
        fu_pkt[3] = mk(6'd33, 1'b0, 1'b0);
        smp();
        nxt();
        fu_valid = '0;
        smp();
        chk("t5_rr0_grant", 64'(wb_grant_idx), 64'd1);
        chk("t5_rr0_rob",   64'(wb_pkt.rob_idx), 64'd31);
        nxt();
        smp();
        chk("t5_rr1_grant", 64'(wb_grant_idx), 64'd3);
        nxt();
        smp();
        chk("t5_empty", 64'(wb_valid), 64'd0);

        // T6: asynchronous reset while stalled with all buffers full
        nxt();
        wb_ready = 1'b0;
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) fu_pkt[i] = mk(6'(40 + i), 1'b0, 1'b0);
        smp();
        nxt();
        fu_valid = '0;
        smp();
        chk("t6_pre_valid", 64'(wb_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(wb_valid), 64'd0);
        chk("t6_rst_fire",  64'(cdb_fire), 64'd0);
        chk("t6_rst_pkt",   64'(wb_pkt),   64'd0);
        chk("t6_rst_grant", 64'(wb_grant_idx), 64'd0);
        chk("t6_rst_ready", 64'(fu_ready), 64'hF);
        nxt();
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        smp();
        chk("t6_after_valid", 64'(wb_valid), 64'd0);
        chk("t6_after_ready", 64'(fu_ready), 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
